// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: strobe/config inputs and detection status outputs of the detector
interface seq_detector_param_if #(
   parameter int SEQ_LEN = 5,
   parameter int CNT_W   = 8
);
   logic               bit_valid;
   logic               seq_in;
   logic [SEQ_LEN-1:0] pattern;
   logic [SEQ_LEN-1:0] mask;
   logic               overlap_en;
   logic               clear;
   logic [SEQ_LEN-1:0] shreg_out;
   logic               match_pulse;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;
   modport master (
      output bit_valid, seq_in, pattern, mask, overlap_en, clear,
      input  shreg_out, match_pulse, match_cnt, cnt_sat
   );
   modport slave (
      input  bit_valid, seq_in, pattern, mask, overlap_en, clear,
      output shreg_out, match_pulse, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: masked serial pattern detector with overlap control and saturating match count
module seq_detector_param #(
   parameter int SEQ_LEN = 5,
   parameter int CNT_W   = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   seq_detector_param_if.slave  bus
);
   localparam int FW = $clog2(SEQ_LEN + 1);
   typedef enum logic {FILL, ARMED} state_t;
   state_t             r_state;
   logic [FW-1:0]      r_fill;
   logic [SEQ_LEN-1:0] r_shreg;
   logic               r_pulse;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_sat;
   logic [SEQ_LEN-1:0] w_shreg_next;
   logic [FW-1:0]      w_fill_next;
   logic               w_hit;
   logic               w_restart;
   logic [CNT_W-1:0]   w_cnt_next;
   if (SEQ_LEN == 1) begin : g_one
      assign w_shreg_next = bus.seq_in;
   end else begin : g_multi
      assign w_shreg_next = {r_shreg[SEQ_LEN-2:0], bus.seq_in};
   end
   // Match is judged on the history and fill as they will be after this bit lands
   always_comb begin
      w_fill_next = (r_state == ARMED) ? r_fill : r_fill + FW'(1);
      w_hit       = bus.bit_valid && (w_fill_next == FW'(SEQ_LEN))
                    && (((w_shreg_next ^ bus.pattern) & bus.mask) == '0);
      w_restart   = w_hit && !bus.overlap_en;
      w_cnt_next  = (w_hit && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_fill  <= '0;
         r_shreg <= '0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
      end else if (bus.clear) begin
         r_state <= FILL;
         r_fill  <= '0;
         r_shreg <= '0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_pulse <= w_hit;
         r_cnt   <= w_cnt_next;
         r_sat   <= &w_cnt_next;
         if (bus.bit_valid) begin
            r_shreg <= w_shreg_next;
            r_fill  <= w_restart ? '0 : w_fill_next;
            r_state <= (!w_restart && w_fill_next == FW'(SEQ_LEN)) ? ARMED : FILL;
         end
      end
   end
   assign bus.shreg_out   = r_shreg;
   assign bus.match_pulse = r_pulse;
   assign bus.match_cnt   = r_cnt;
   assign bus.cnt_sat     = r_sat;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed table, corner sequences and random stimulus vs a history-queue model
module tb_seq_detector_param;
   localparam int N = 5;
   logic clk = 0, rst_n = 1, valid = 0, sin = 0, clr = 0, ov = 1;
   logic [N-1:0] pat = '0, msk = '1;
   int total = 0, passed = 0, pulses = 0;
   seq_detector_param_if #(.SEQ_LEN(N), .CNT_W(8)) ifa ();
   seq_detector_param_if #(.SEQ_LEN(N), .CNT_W(2)) ifb ();
   assign ifa.bit_valid = valid;
   assign ifa.seq_in = sin;
   assign ifa.pattern = pat;
   assign ifa.mask = msk;
   assign ifa.overlap_en = ov;
   assign ifa.clear = clr;
   assign ifb.bit_valid = valid;
   assign ifb.seq_in = sin;
   assign ifb.pattern = pat;
   assign ifb.mask = msk;
   assign ifb.overlap_en = ov;
   assign ifb.clear = clr;
   seq_detector_param #(.SEQ_LEN(N), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   seq_detector_param #(.SEQ_LEN(N), .CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
   always #5 clk = ~clk;
   // Model: last N bits as a queue (oldest first), a bit count and per-instance match totals
   bit hist[$];
   int m_fill;
   int m_cnt[2];
   bit m_pulse;
   int maxc[2] = '{255, 3};
   function automatic void m_reset();
      hist = {};
      for (int i = 0; i < N; i++) hist.push_back(1'b0);
      m_fill = 0;
      m_cnt = '{0, 0};
      m_pulse = 0;
   endfunction
   function automatic bit m_match();
      for (int i = 0; i < N; i++)
         if (msk[i] && hist[N-1-i] != pat[i]) return 0;
      return 1;
   endfunction
   function automatic void m_step(bit v, bit b, bit c);
      m_pulse = 0;
      if (c) begin m_reset(); return; end
      if (!v) return;
      hist.push_back(b);
      void'(hist.pop_front());
      if (m_fill < N) m_fill++;
      if (m_fill == N && m_match()) begin
         m_pulse = 1;
         for (int k = 0; k < 2; k++) if (m_cnt[k] < maxc[k]) m_cnt[k]++;
         if (!ov) m_fill = 0;
      end
   endfunction
   task automatic chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask
   task automatic check_all();
      logic [N-1:0] s;
      for (int i = 0; i < N; i++) s[i] = hist[N-1-i];
      chk("shreg_a", int'(ifa.shreg_out), int'(s));
      chk("shreg_b", int'(ifb.shreg_out), int'(s));
      chk("pulse_a", int'(ifa.match_pulse), int'(m_pulse));
      chk("pulse_b", int'(ifb.match_pulse), int'(m_pulse));
      chk("cnt_a", int'(ifa.match_cnt), m_cnt[0]);
      chk("cnt_b", int'(ifb.match_cnt), m_cnt[1]);
      chk("sat_a", int'(ifa.cnt_sat), int'(m_cnt[0] == maxc[0]));
      chk("sat_b", int'(ifb.cnt_sat), int'(m_cnt[1] == maxc[1]));
   endtask
   task automatic step(bit v, bit b, bit c);
      @(negedge clk);
      valid = v; sin = b; clr = c;
      @(posedge clk);
      #1;
      m_step(v, b, c);
      check_all();
      if (ifa.match_pulse) pulses++;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; valid = 1; sin = 1; clr = 0;
      #2;
      m_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1; valid = 0;
   endtask
   task automatic bits5(logic [N-1:0] v);
      for (int i = N - 1; i >= 0; i--) step(1, v[i], 0);
   endtask
   typedef struct {
      logic [N-1:0] p, m;
      bit o, v, b, c, ep;
      int ec;
   } vec_t;
   vec_t tbl[$];
   function automatic void add(logic [N-1:0] p, m, bit o, v, b, c, ep, int ec);
      tbl.push_back('{p, m, o, v, b, c, ep, ec});
   endfunction
   initial begin
      add(5'b10110, 5'b11111, 1, 0, 0, 1, 0, 0);
      add(5'b10110, 5'b11111, 1, 1, 1, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 1, 0, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 1, 1, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 1, 1, 0, 0, 0);
      add(5'b10110, 5'b11111, 1, 1, 0, 0, 1, 1);
      add(5'b10110, 5'b11111, 1, 0, 0, 0, 0, 1);
      for (int o = 1; o >= 0; o--) begin
         add(5'b10101, 5'b11111, 1'(o), 0, 0, 1, 0, 0);
         for (int i = 0; i < 7; i++)
            add(5'b10101, 5'b11111, 1'(o), 1, 1'(~i & 1), 0,
                (i == 4) || (o == 1 && i == 6), (i < 4) ? 0 : (o == 1 && i == 6) ? 2 : 1);
      end
      add(5'b10001, 5'b10001, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(5'b10001, 5'b10001, 1, 1, 1, 0, i == 4, (i == 4) ? 1 : 0);
      add(5'b10001, 5'b10001, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(5'b10001, 5'b10001, 1, 1, 1'(~i & 1), 0, i == 4, (i == 4) ? 1 : 0);
      add(5'b10001, 5'b10001, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(5'b10001, 5'b10001, 1, 1, i != 0, 0, 0, 0);
      add(5'b00000, 5'b00000, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) add(5'b00000, 5'b00000, 1, 1, 1'(i), 0, i >= 4, (i < 4) ? 0 : i - 3);
      #1 rst_n = 0;
      #2;
      m_reset();
      check_all();
      @(negedge clk);
      rst_n = 1;
      foreach (tbl[i]) begin
         pat = tbl[i].p; msk = tbl[i].m; ov = tbl[i].o;
         step(tbl[i].v, tbl[i].b, tbl[i].c);
         chk("tbl_pulse", int'(ifa.match_pulse), int'(tbl[i].ep));
         chk("tbl_cnt", int'(ifa.match_cnt), tbl[i].ec);
      end
      // Bits separated by idle gaps: history must hold and exactly one single-cycle pulse appears
      step(0, 0, 1);
      pat = 5'b10110; msk = '1; ov = 1; pulses = 0;
      for (int i = N - 1; i >= 0; i--) begin
         logic [N-1:0] prev;
         step(1, pat[i], 0);
         repeat ($urandom_range(1, 3)) begin
            prev = ifa.shreg_out;
            step(0, 0, 0);
            chk("gap_hold", int'(ifa.shreg_out), int'(prev));
            chk("gap_pulse_low", int'(ifa.match_pulse), 0);
         end
      end
      chk("gap_pulses", pulses, 1);
      // Counter saturation on the narrow instance, then clear beating a simultaneous valid bit
      step(0, 0, 1);
      msk = '0;
      repeat (9) step(1, 1'($urandom), 0);
      chk("sat_cnt_b", int'(ifb.match_cnt), 3);
      chk("sat_flag_b", int'(ifb.cnt_sat), 1);
      chk("sat_cnt_a", int'(ifa.match_cnt), 5);
      step(1, 1, 1);
      chk("clr_cnt", int'(ifb.match_cnt), 0);
      chk("clr_shreg", int'(ifa.shreg_out), 0);
      chk("clr_sat", int'(ifb.cnt_sat), 0);
      pulses = 0;
      repeat (4) step(1, 1'($urandom), 0);
      chk("clr_refill_pulses", pulses, 0);
      // Async reset mid-pattern discards the partial history
      step(0, 0, 1);
      pat = 5'b10110; msk = '1;
      step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      do_reset();
      pulses = 0;
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
      chk("rst_resume_pulses", pulses, 0);
      bits5(5'b10110);
      chk("rst_full_match", int'(ifa.match_pulse), 1);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) pat = N'($urandom);
         if ($urandom_range(0, 39) == 0) msk = N'($urandom);
         if ($urandom_range(0, 59) == 0) ov = ~ov;
         if ($urandom_range(0, 299) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 149) == 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
